// File: rtl/iob_cache_axi_linefill_pkg.sv
// Shared constants for the AXI4 line-fill engine.
//   - AXI burst type encodings
//   - rresp error bit (set for both SLVERR and DECERR)
//   - FSM state encodings
//   - wrap_legal(): decides whether a WRAP burst can be used for a line size
package iob_cache_axi_linefill_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  // rresp[1] is set for SLVERR (2'b10) and DECERR (2'b11)
  localparam int RESP_ERR_BIT = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // AXI4 WRAP bursts must be 2, 4, 8 or 16 beats long
  function automatic bit wrap_legal(input int wrap_en, input int line2mem_w);
    return (wrap_en != 0) && (line2mem_w >= 1) && (line2mem_w <= 4);
  endfunction

endpackage

// File: rtl/iob_cache_axi_linefill_beat_counter.sv
// Modular up-counter used to count accepted beats of a line fill.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   load_i          load load_val_i (takes priority over en_i)
//   load_val_i      value to load
//   en_i            advance by one; wraps to 0 after MAX
//   cnt_o           current count
//   tc_o            terminal count (cnt_o == MAX)
module iob_cache_axi_linefill_beat_counter #(
  parameter int             W   = 3,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = load_val_i;
    else if (en_i) cnt_d = (cnt_q == MAX) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == MAX);

endmodule

// File: rtl/iob_cache_axi_linefill.sv
// AXI4 read-channel line-fill engine. Fetches one cache line as a single
// burst (critical-beat-first WRAP when legal, else INCR from the line base)
// and streams the beats into the cache line write port.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   replace_valid/replace_addr line-fill request, beat address of missed word
//   replace                    engine busy
//   read_valid/read_addr/read_rdata  beat write strobe, beat index, data
//   crit_valid                 pulse when the requested beat is written
//   fill_err                   pulse at fill end if any beat was bad
//   m_axi_ar*                  AXI read address channel
//   m_axi_r*                   AXI read data channel (rid ignored)
module iob_cache_axi_linefill
  import iob_cache_axi_linefill_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BYTE_W     = $clog2(DATA_W / 8),  // derived, do not override
  parameter int LINE2MEM_W = 3,
  parameter int WRAP_EN    = 1,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ID     = 0,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             replace_valid,
  input  logic [ADDR_W-BYTE_W-1:0]         replace_addr,
  output logic                             replace,
  output logic                             read_valid,
  output logic [((LINE2MEM_W>0)?LINE2MEM_W:1)-1:0] read_addr,
  output logic [DATA_W-1:0]                read_rdata,
  output logic                             crit_valid,
  output logic                             fill_err,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  output logic [ADDR_W-1:0]                m_axi_araddr,
  output logic [AXI_LEN_W-1:0]             m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic [AXI_ID_W-1:0]              m_axi_arid,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready,
  input  logic [DATA_W-1:0]                m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic [AXI_ID_W-1:0]              m_axi_rid
);

  localparam int          RA_W     = (LINE2MEM_W > 0) ? LINE2MEM_W : 1;
  localparam int          BA_W     = ADDR_W - BYTE_W;
  localparam int unsigned BEATS    = 1 << LINE2MEM_W;
  localparam logic [RA_W-1:0] LAST = RA_W'(BEATS - 1);
  localparam logic [BA_W-1:0] LMASK = BA_W'(BEATS - 1);
  localparam bit          USE_WRAP = wrap_legal(WRAP_EN, LINE2MEM_W);

  logic [1:0]      state_q, state_d;
  logic [BA_W-1:0] addr_q, addr_d;
  logic            err_q, err_d;

  logic            start, beat, last_beat;
  logic [RA_W-1:0] cnt, base, crit_off;
  logic [BA_W-1:0] ar_beat;
  logic            unused_in;

  assign unused_in = ^{m_axi_rid, m_axi_rresp[0]};

  assign start = (state_q == ST_IDLE) & replace_valid;
  assign beat  = (state_q == ST_DATA) & m_axi_rvalid;

  // Counts accepted beats 0..BEATS-1; tc marks the final beat, so the fill
  // length is fixed by the count and not by rlast.
  iob_cache_axi_linefill_beat_counter #(
    .W   (RA_W),
    .MAX (LAST)
  ) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start),
    .load_val_i ('0),
    .en_i       (beat),
    .cnt_o      (cnt),
    .tc_o       (last_beat)
  );

  // Beat index = first beat of the burst + beats accepted, modulo line size.
  // A WRAP burst starts at the critical beat, INCR starts at beat 0.
  assign crit_off  = (LINE2MEM_W == 0) ? '0 : addr_q[RA_W-1:0];
  assign base      = USE_WRAP ? crit_off : '0;
  assign read_addr = base + cnt;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (replace_valid) begin
        addr_d  = replace_addr;
        err_d   = 1'b0;
        state_d = ST_ADDR;
      end
      ST_ADDR: if (m_axi_arready) state_d = ST_DATA;
      ST_DATA: if (m_axi_rvalid) begin
        // rlast must be high exactly on the counted final beat
        err_d = err_q | m_axi_rresp[RESP_ERR_BIT] | (m_axi_rlast != last_beat);
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign ar_beat = USE_WRAP ? addr_q : (addr_q & ~LMASK);

  // AR payload is driven only while arvalid is up so every output reads 0
  // when idle or in reset.
  assign replace       = (state_q != ST_IDLE);
  assign m_axi_arvalid = (state_q == ST_ADDR);
  assign m_axi_araddr  = m_axi_arvalid ? (ADDR_W'(ar_beat) << BYTE_W) : '0;
  assign m_axi_arlen   = m_axi_arvalid ? AXI_LEN_W'(BEATS - 1) : '0;
  assign m_axi_arsize  = m_axi_arvalid ? 3'(BYTE_W) : '0;
  assign m_axi_arburst = m_axi_arvalid ? (USE_WRAP ? BURST_WRAP : BURST_INCR) : '0;
  assign m_axi_arid    = m_axi_arvalid ? AXI_ID_W'(AXI_ID) : '0;
  assign m_axi_rready  = (state_q == ST_DATA);

  assign read_valid = beat;
  assign read_rdata = (state_q == ST_DATA) ? m_axi_rdata : '0;
  assign crit_valid = beat & (read_addr == crit_off);
  assign fill_err   = (state_q == ST_DONE) & err_q;

endmodule
